// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock, valid/ready on both sides.
// Optional BOOTH_MAC_EN adds an acc_en input and a running accumulator on the product.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_MAC_EN
    input  logic               acc_en,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    localparam int XW = WIDTH + 2;
    localparam int N  = XW / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       a_q, a_d;
    logic [2*XW-1:0]     p_q, p_d;
    logic                bm1_q, bm1_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  res_q, res_d;
`ifdef BOOTH_MAC_EN
    logic                acc_en_q, acc_en_d;
`endif

    logic [2:0]          digit;
    logic [XW+1:0]       a_sx, mag, addend, upper_sx, sum;
    logic                neg;
    logic [2*XW-1:0]     step_p;

    function automatic logic [XW-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
        return s ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = res_q;

    // Two guard bits on the upper half absorb +-2A before the 2-bit arithmetic shift.
    always_comb begin
        mag   = '0;
        neg   = 1'b0;
        digit = {p_q[1:0], bm1_q};
        a_sx  = {{2{a_q[XW-1]}}, a_q};
        case (digit)
            3'b001, 3'b010: mag = a_sx;
            3'b011:         mag = a_sx << 1;
            3'b100: begin
                mag = a_sx << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = a_sx;
                neg = 1'b1;
            end
            default: ;
        endcase
        addend   = neg ? ~mag : mag;
        upper_sx = {{2{p_q[2*XW-1]}}, p_q[2*XW-1:XW]};
        sum      = upper_sx + addend + {{(XW+1){1'b0}}, neg};
        step_p   = {sum, p_q[XW-1:2]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        p_d      = p_q;
        bm1_d    = bm1_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
`ifdef BOOTH_MAC_EN
        acc_en_d = acc_en_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = ext(multiplicand, signed_mode);
                    p_d      = {{XW{1'b0}}, ext(multiplier, signed_mode)};
                    bm1_d    = 1'b0;
                    cnt_d    = CW'(N - 1);
`ifdef BOOTH_MAC_EN
                    acc_en_d = acc_en;
`endif
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                p_d   = step_p;
                bm1_d = p_q[1];
                if (cnt_q == '0) begin
                    state_d = DONE;
`ifdef BOOTH_MAC_EN
                    res_d = acc_en_q ? res_q + step_p[2*WIDTH-1:0] : step_p[2*WIDTH-1:0];
`else
                    res_d = step_p[2*WIDTH-1:0];
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            p_q      <= '0;
            bm1_q    <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
`ifdef BOOTH_MAC_EN
            acc_en_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            p_q      <= p_d;
            bm1_q    <= bm1_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
`ifdef BOOTH_MAC_EN
            acc_en_q <= acc_en_d;
`endif
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8): directed cases plus random operands
// against a plain-arithmetic reference.
module tb_booth_mult_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        signed_mode;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
`ifdef BOOTH_MAC_EN
    logic        acc_en;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] acc_model = '0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef BOOTH_MAC_EN
        .acc_en       (acc_en),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ai, bi, p;
        ai = s ? int'($signed(a)) : int'(a);
        bi = s ? int'($signed(b)) : int'(b);
        p  = ai * bi;
        return p[15:0];
    endfunction

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input int hold, input logic acc, input logic [15:0] raw, input string tag);
        int cyc;
        logic [15:0] exp, held;
`ifdef BOOTH_MAC_EN
        exp = acc ? acc_model + raw : raw;
        acc_en = acc;
`else
        exp = raw;
`endif
        acc_model = exp;
        chk({tag, "_in_ready"}, in_ready, 1);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = s;
        in_valid     = 1'b1;
        out_ready    = (hold == 0);
        @(posedge clk); #1;
        // Scramble inputs to show they are not re-sampled mid-operation.
        in_valid     = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        signed_mode  = 1'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, cyc, 5);
        chk({tag, "_product"}, product, exp);
        held = product;
        for (int i = 0; i < hold; i++) begin
            in_valid     = 1'($urandom);
            multiplicand = 8'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_product"}, product, held);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_rise"}, in_ready, 1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        int         seen;
        rst          = 1'b1;
        in_valid     = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        out_ready    = 1'b1;
`ifdef BOOTH_MAC_EN
        acc_en       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_product", product, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        txn(8'd3, 8'd4, 1'b1, 0, 1'b0, 16'd12, "s_3x4");
        txn(8'hFC, 8'd3, 1'b1, 0, 1'b0, 16'hFFF4, "s_m4x3");
        txn(8'd3, 8'hFC, 1'b1, 0, 1'b0, 16'hFFF4, "s_3xm4");
        txn(8'hB8, 8'd100, 1'b1, 0, 1'b0, 16'hE3E0, "s_m72x100");
        txn(8'd100, 8'hB8, 1'b1, 0, 1'b0, 16'hE3E0, "s_100xm72");
        txn(8'hB8, 8'd0, 1'b1, 0, 1'b0, 16'h0000, "s_m72x0");
        txn(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 16'h0001, "s_ffxff");
        txn(8'hFF, 8'hFF, 1'b0, 0, 1'b0, 16'hFE01, "u_ffxff");
        txn(8'h80, 8'h80, 1'b1, 0, 1'b0, 16'h4000, "s_m128sq");
        txn(8'd7, 8'd9, 1'b1, 10, 1'b0, 16'd63, "backpressure");

        // Reset during the second BUSY cycle must discard the operation.
        multiplicand = 8'd36;
        multiplier   = 8'd4;
        signed_mode  = 1'b1;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        acc_model = '0;
        chk("midrst_product", product, 0);
        chk("midrst_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst_no_valid", seen, 0);
        txn(8'd36, 8'd4, 1'b1, 0, 1'b0, 16'd144, "after_rst");

`ifdef BOOTH_MAC_EN
        txn(8'd3, 8'd4, 1'b1, 0, 1'b0, 16'd12, "mac0");
        txn(8'hB8, 8'd50, 1'b1, 0, 1'b1, ref_mul(8'hB8, 8'd50, 1'b1), "mac1");
        chk("mac1_value", product, 16'($signed(-3588)));
        txn(8'd100, 8'hB8, 1'b1, 0, 1'b1, ref_mul(8'd100, 8'hB8, 1'b1), "mac2");
        chk("mac2_value", product, 16'($signed(-10788)));
`endif

        for (int t = 0; t < 30; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            txn(ra, rb, rs, int'($urandom_range(0, 2)), 1'b0, ref_mul(ra, rb, rs), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
